// File: rtl/patch_scan_ctrl_if.sv
// Command, configuration and generator-drive signals of the patch scan sequencer.
// Suffixes are from the sequencer's point of view (slave modport).
interface patch_scan_ctrl_if #(
  parameter int XW = 6,
  parameter int YW = 6
);
  logic          start_i;
  logic          abort_i;
  logic [2:0]    cfg_stride_i;
  logic [2:0]    cfg_patch_i;
  logic [XW-1:0] cfg_width_i;
  logic [YW-1:0] cfg_height_i;
  logic          pe_ready_i;
  logic          ag_done_i;
  logic          ag_en_o;
  logic [5:0]    ag_cycle_cnt_o;
  logic [2:0]    ag_k_o;
  logic [XW-1:0] ag_xcor_o;
  logic [2:0]    ag_stride_o;
  logic [2:0]    ag_patch_o;
  logic [YW-1:0] ag_height_o;
  logic          busy_o;
  logic          scan_done_o;
  logic          cfg_err_o;
  logic          overflow_o;

  modport slave (
    input  start_i, abort_i, cfg_stride_i, cfg_patch_i, cfg_width_i, cfg_height_i,
           pe_ready_i, ag_done_i,
    output ag_en_o, ag_cycle_cnt_o, ag_k_o, ag_xcor_o, ag_stride_o, ag_patch_o,
           ag_height_o, busy_o, scan_done_o, cfg_err_o, overflow_o
  );

  modport master (
    output start_i, abort_i, cfg_stride_i, cfg_patch_i, cfg_width_i, cfg_height_i,
           pe_ready_i, ag_done_i,
    input  ag_en_o, ag_cycle_cnt_o, ag_k_o, ag_xcor_o, ag_stride_o, ag_patch_o,
           ag_height_o, busy_o, scan_done_o, cfg_err_o, overflow_o
  );
endinterface

// File: rtl/patch_scan_ctrl.sv
// Patch scan sequencer: steps k lane, x position and 8-row band for the patch
// address generator; a scan ends on the generator's done flag or band overflow.
module patch_scan_ctrl #(
  parameter  int WIDTH  = 32,
  parameter  int HEIGHT = 32,
  parameter  int CC_MAX = 63,
  localparam int XW     = $clog2(WIDTH) + 1,
  localparam int YW     = $clog2(HEIGHT) + 1
) (
  input  logic             clk,
  input  logic             rst,
  patch_scan_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_ERR, S_RUN, S_DRAIN, S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    k_q, k_d;
  logic [XW-1:0] x_q, x_d;
  logic [5:0]    cc_q, cc_d;
  logic [2:0]    stride_q, stride_d;
  logic [2:0]    patch_q, patch_d;
  logic [YW-1:0] height_q, height_d;
  logic [XW-1:0] width_q, width_d;
  logic [XW-1:0] x_last_q, x_last_d;
  logic [3:0]    k_cnt_q, k_cnt_d;
  logic          overflow_q, overflow_d;
  logic          done_seen_q, done_seen_d;
  logic          drain_q, drain_d;

  logic          cfg_bad;
  logic [XW:0]   x_next;
  logic          k_wrap;
  logic          row_end;
  logic          done_now;

  // Lanes per x step: wider strides need fewer k lanes to cover the patch.
  function automatic logic [3:0] k_count(input logic [2:0] s);
    case (s)
      3'd1:    return 4'd8;
      3'd2:    return 4'd4;
      3'd3:    return 4'd3;
      3'd0:    return 4'd1;
      default: return 4'd2;
    endcase
  endfunction

  assign cfg_bad  = !(patch_q inside {3'd3, 3'd5, 3'd7}) || (stride_q == 3'd0)
                 || (patch_q == 3'd3 && (stride_q == 3'd4 || stride_q == 3'd5))
                 || (width_q < XW'(patch_q));
  assign x_next   = {1'b0, x_q} + (XW+1)'(stride_q);
  assign k_wrap   = ({1'b0, k_q} == k_cnt_q - 4'd1);
  assign row_end  = k_wrap && (x_next > {1'b0, x_last_q});
  assign done_now = done_seen_q || bus.ag_done_i;

  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
    state_d     = state_q;
    k_d         = k_q;
    x_d         = x_q;
    cc_d        = cc_q;
    stride_d    = stride_q;
    patch_d     = patch_q;
    height_d    = height_q;
    width_d     = width_q;
    x_last_d    = x_last_q;
    k_cnt_d     = k_cnt_q;
    overflow_d  = overflow_q;
    done_seen_d = done_seen_q;
    drain_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start_i && !bus.abort_i) begin
          stride_d    = bus.cfg_stride_i;
          patch_d     = bus.cfg_patch_i;
          height_d    = bus.cfg_height_i;
          width_d     = bus.cfg_width_i;
          overflow_d  = 1'b0;
          done_seen_d = 1'b0;
          k_d         = 3'd0;
          x_d         = XW'(1);
          cc_d        = 6'd1;
          state_d     = S_CHECK;
        end
      end
      S_CHECK: begin
        x_last_d = width_q - XW'(patch_q) + XW'(1);
        k_cnt_d  = k_count(stride_q);
        state_d  = cfg_bad ? S_ERR : S_RUN;
      end
      S_ERR: state_d = S_IDLE;
      S_RUN: begin
        if (bus.ag_done_i) done_seen_d = 1'b1;
        if (bus.pe_ready_i) begin
          if (row_end) begin
            // Counters hold on the way into DRAIN so the generator sees the last beat.
            if (done_now) begin
              state_d = S_DRAIN;
            end else if (cc_q == 6'(CC_MAX)) begin
              overflow_d = 1'b1;
              state_d    = S_DRAIN;
            end else begin
              k_d  = 3'd0;
              x_d  = XW'(1);
              cc_d = cc_q + 6'd1;
            end
          end else if (k_wrap) begin
            k_d = 3'd0;
            x_d = x_next[XW-1:0];
          end else begin
            k_d = k_q + 3'd1;
          end
        end
      end
      S_DRAIN: begin
        if (bus.ag_done_i) done_seen_d = 1'b1;
        drain_d = !drain_q;
        if (drain_q) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (bus.abort_i) state_d = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      k_q         <= 3'd0;
      x_q         <= XW'(1);
      cc_q        <= 6'd1;
      stride_q    <= 3'd0;
      patch_q     <= 3'd0;
      height_q    <= '0;
      width_q     <= '0;
      x_last_q    <= '0;
      k_cnt_q     <= 4'd0;
      overflow_q  <= 1'b0;
      done_seen_q <= 1'b0;
      drain_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      k_q         <= k_d;
      x_q         <= x_d;
      cc_q        <= cc_d;
      stride_q    <= stride_d;
      patch_q     <= patch_d;
      height_q    <= height_d;
      width_q     <= width_d;
      x_last_q    <= x_last_d;
      k_cnt_q     <= k_cnt_d;
      overflow_q  <= overflow_d;
      done_seen_q <= done_seen_d;
      drain_q     <= drain_d;
    end
  end

  assign bus.ag_en_o        = (state_q == S_RUN);
  assign bus.busy_o         = (state_q inside {S_CHECK, S_RUN, S_DRAIN});
  assign bus.scan_done_o    = (state_q == S_DONE);
  assign bus.cfg_err_o      = (state_q == S_ERR);
  assign bus.overflow_o     = overflow_q;
  assign bus.ag_cycle_cnt_o = cc_q;
  assign bus.ag_k_o         = k_q;
  assign bus.ag_xcor_o      = x_q;
  assign bus.ag_stride_o    = stride_q;
  assign bus.ag_patch_o     = patch_q;
  assign bus.ag_height_o    = height_q;

endmodule

// File: tb/tb_patch_scan_ctrl.sv
// Directed bench for patch_scan_ctrl: full scans, config rejection, stalls,
// band overflow (second instance with CC_MAX=3), abort and async reset.
module tb_patch_scan_ctrl;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  patch_scan_ctrl_if #(.XW(6), .YW(6)) bus1 ();
  patch_scan_ctrl_if #(.XW(6), .YW(6)) bus2 ();

  patch_scan_ctrl #(.WIDTH(32), .HEIGHT(32), .CC_MAX(63)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  patch_scan_ctrl #(.WIDTH(32), .HEIGHT(32), .CC_MAX(3)) dut_ovf (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {ag_en, busy, scan_done, cfg_err, overflow, cc, k, x, stride, patch, height}
  localparam logic [31:0] RST_VEC = {5'b0, 6'd1, 3'd0, 6'd1, 3'd0, 3'd0, 6'd0};

  function automatic logic [31:0] snap1();
    return {bus1.ag_en_o, bus1.busy_o, bus1.scan_done_o, bus1.cfg_err_o, bus1.overflow_o,
            bus1.ag_cycle_cnt_o, bus1.ag_k_o, bus1.ag_xcor_o, bus1.ag_stride_o,
            bus1.ag_patch_o, bus1.ag_height_o};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch1(input logic [2:0] s, input logic [2:0] p,
                         input logic [5:0] w, input logic [5:0] h);
    bus1.cfg_stride_i = s;
    bus1.cfg_patch_i  = p;
    bus1.cfg_width_i  = w;
    bus1.cfg_height_i = h;
    bus1.start_i      = 1'b1;
    tick();
    bus1.start_i      = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus1.start_i = 0; bus1.abort_i = 0; bus1.pe_ready_i = 1; bus1.ag_done_i = 0;
    bus1.cfg_stride_i = 0; bus1.cfg_patch_i = 0; bus1.cfg_width_i = 0; bus1.cfg_height_i = 0;
    bus2.start_i = 0; bus2.abort_i = 0; bus2.pe_ready_i = 1; bus2.ag_done_i = 0;
    bus2.cfg_stride_i = 0; bus2.cfg_patch_i = 0; bus2.cfg_width_i = 0; bus2.cfg_height_i = 0;
    #3;
    checks++;
    if (snap1() !== RST_VEC) begin
      errors++; $display("FAIL reset_state: got %h want %h", snap1(), RST_VEC);
    end
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++;
    if (snap1() !== RST_VEC) begin
      errors++; $display("FAIL reset_release: got %h want %h", snap1(), RST_VEC);
    end
  endtask

  // patch 3, stride 1, width 32, done flag during band 4
  task automatic test_full_scan();
    int bad = 0;
    int en_cnt = 0;
    launch1(3'd1, 3'd3, 6'd32, 6'd20);
    for (int b = 1; b <= 4; b++)
      for (int x = 1; x <= 30; x++)
        for (int k = 0; k < 8; k++) begin
          if (bus1.ag_en_o === 1'b1) en_cnt++;
          if (bus1.ag_cycle_cnt_o !== 6'(b) || bus1.ag_xcor_o !== 6'(x) || bus1.ag_k_o !== 3'(k))
            bad++;
          bus1.ag_done_i = (b == 4 && x == 5 && k == 3);
          tick();
        end
    bus1.ag_done_i = 1'b0;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL full_seq: got %0d bad beats want 0", bad); end
    checks++;
    if (en_cnt !== 960) begin errors++; $display("FAIL full_en_count: got %0d want 960", en_cnt); end
    checks++;
    if ({bus1.ag_stride_o, bus1.ag_patch_o, bus1.ag_height_o} !== {3'd1, 3'd3, 6'd20}) begin
      errors++; $display("FAIL full_latched_cfg: got %h want %h",
                         {bus1.ag_stride_o, bus1.ag_patch_o, bus1.ag_height_o}, {3'd1, 3'd3, 6'd20});
    end
    checks++;
    if ({bus1.ag_en_o, bus1.busy_o, bus1.ag_cycle_cnt_o, bus1.ag_xcor_o, bus1.ag_k_o}
        !== {1'b0, 1'b1, 6'd4, 6'd30, 3'd7}) begin
      errors++; $display("FAIL full_drain_hold: got %h want %h",
                         {bus1.ag_en_o, bus1.busy_o, bus1.ag_cycle_cnt_o, bus1.ag_xcor_o, bus1.ag_k_o},
                         {1'b0, 1'b1, 6'd4, 6'd30, 3'd7});
    end
    tick();
    checks++;
    if (bus1.scan_done_o !== 1'b0 || bus1.ag_en_o !== 1'b0) begin
      errors++; $display("FAIL full_drain2: got done=%0d en=%0d want 0 0", bus1.scan_done_o, bus1.ag_en_o);
    end
    tick();
    checks++;
    if ({bus1.scan_done_o, bus1.busy_o, bus1.overflow_o} !== 3'b100) begin
      errors++; $display("FAIL full_scan_done: got %b want 100",
                         {bus1.scan_done_o, bus1.busy_o, bus1.overflow_o});
    end
    tick();
    checks++;
    if (bus1.scan_done_o !== 1'b0) begin
      errors++; $display("FAIL full_done_pulse: got %0d want 0", bus1.scan_done_o);
    end
  endtask

  // patch 5, stride 2, width 16, done flag held high: a single band of 24 beats
  task automatic test_stride2();
    int bad = 0;
    bus1.ag_done_i = 1'b1;
    launch1(3'd2, 3'd5, 6'd16, 6'd12);
    for (int x = 1; x <= 11; x += 2)
      for (int k = 0; k < 4; k++) begin
        if (bus1.ag_en_o !== 1'b1 || bus1.ag_cycle_cnt_o !== 6'd1 ||
            bus1.ag_xcor_o !== 6'(x) || bus1.ag_k_o !== 3'(k))
          bad++;
        tick();
      end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL s2_seq: got %0d bad beats want 0", bad); end
    checks++;
    if ({bus1.ag_en_o, bus1.ag_cycle_cnt_o, bus1.ag_xcor_o, bus1.ag_k_o} !== {1'b0, 6'd1, 6'd11, 3'd3}) begin
      errors++; $display("FAIL s2_end: got %h want %h",
                         {bus1.ag_en_o, bus1.ag_cycle_cnt_o, bus1.ag_xcor_o, bus1.ag_k_o},
                         {1'b0, 6'd1, 6'd11, 3'd3});
    end
    tick(); tick();
    checks++;
    if (bus1.scan_done_o !== 1'b1) begin
      errors++; $display("FAIL s2_scan_done: got %0d want 1", bus1.scan_done_o);
    end
    bus1.ag_done_i = 1'b0;
    tick();
  endtask

  task automatic test_cfg_err();
    logic [2:0] st [6] = '{3'd4, 3'd5, 3'd0, 3'd1, 3'd1, 3'd2};
    logic [2:0] pt [6] = '{3'd3, 3'd3, 3'd3, 3'd4, 3'd7, 3'd2};
    logic [5:0] wd [6] = '{6'd32, 6'd32, 6'd32, 6'd32, 6'd6, 6'd32};
    for (int i = 0; i < 6; i++) begin
      logic en_seen;
      en_seen = 1'b0;
      bus1.cfg_stride_i = st[i]; bus1.cfg_patch_i = pt[i]; bus1.cfg_width_i = wd[i];
      bus1.start_i = 1'b1;
      tick();
      bus1.start_i = 1'b0;
      en_seen |= bus1.ag_en_o;
      tick();
      en_seen |= bus1.ag_en_o;
      checks++;
      if ({bus1.cfg_err_o, bus1.busy_o} !== 2'b10) begin
        errors++; $display("FAIL cfg_err_pulse[%0d]: got %b want 10", i, {bus1.cfg_err_o, bus1.busy_o});
      end
      tick();
      en_seen |= bus1.ag_en_o;
      checks++;
      if ({bus1.cfg_err_o, bus1.busy_o, en_seen} !== 3'b000) begin
        errors++; $display("FAIL cfg_err_after[%0d]: got %b want 000", i,
                           {bus1.cfg_err_o, bus1.busy_o, en_seen});
      end
    end
    // width equal to patch is the smallest legal image
    launch1(3'd3, 3'd3, 6'd3, 6'd3);
    checks++;
    if ({bus1.ag_en_o, bus1.cfg_err_o, bus1.ag_xcor_o, bus1.ag_k_o} !== {2'b10, 6'd1, 3'd0}) begin
      errors++; $display("FAIL cfg_width_eq_patch: got %h want %h",
                         {bus1.ag_en_o, bus1.cfg_err_o, bus1.ag_xcor_o, bus1.ag_k_o}, {2'b10, 6'd1, 3'd0});
    end
    bus1.abort_i = 1'b1;
    tick();
    bus1.abort_i = 1'b0;
  endtask

  // ready pattern with a 2-cycle stall, plus a start pulse mid-run that must be ignored
  task automatic test_stall();
    logic rdy [10] = '{1, 1, 1, 1, 1, 1, 0, 0, 1, 1};
    int exp_k = 0;
    int bad = 0;
    launch1(3'd1, 3'd3, 6'd32, 6'd8);
    for (int i = 0; i < 10; i++) begin
      if (bus1.ag_en_o !== 1'b1 || bus1.ag_k_o !== 3'(exp_k) || bus1.ag_xcor_o !== 6'd1) bad++;
      bus1.pe_ready_i = rdy[i];
      bus1.start_i    = (i == 6);
      tick();
      if (rdy[i]) exp_k++;
    end
    bus1.pe_ready_i = 1'b1;
    bus1.start_i    = 1'b0;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL stall_seq: got %0d bad cycles want 0", bad); end
    checks++;
    if ({bus1.ag_k_o, bus1.ag_xcor_o, bus1.ag_cycle_cnt_o} !== {3'd0, 6'd2, 6'd1}) begin
      errors++; $display("FAIL stall_count: got %h want %h",
                         {bus1.ag_k_o, bus1.ag_xcor_o, bus1.ag_cycle_cnt_o}, {3'd0, 6'd2, 6'd1});
    end
    bus1.abort_i = 1'b1;
    tick();
    bus1.abort_i = 1'b0;
  endtask

  // CC_MAX=3 instance, done flag never raised
  task automatic test_overflow();
    int bad = 0;
    bus2.cfg_stride_i = 3'd1; bus2.cfg_patch_i = 3'd3; bus2.cfg_width_i = 6'd3; bus2.cfg_height_i = 6'd9;
    bus2.start_i = 1'b1;
    tick();
    bus2.start_i = 1'b0;
    tick();
    for (int b = 1; b <= 3; b++)
      for (int k = 0; k < 8; k++) begin
        if (bus2.ag_en_o !== 1'b1 || bus2.ag_cycle_cnt_o !== 6'(b) ||
            bus2.ag_xcor_o !== 6'd1 || bus2.ag_k_o !== 3'(k))
          bad++;
        tick();
      end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL ovf_seq: got %0d bad beats want 0", bad); end
    checks++;
    if ({bus2.ag_en_o, bus2.overflow_o, bus2.ag_cycle_cnt_o} !== {2'b01, 6'd3}) begin
      errors++; $display("FAIL ovf_flag: got %h want %h",
                         {bus2.ag_en_o, bus2.overflow_o, bus2.ag_cycle_cnt_o}, {2'b01, 6'd3});
    end
    tick(); tick();
    checks++;
    if ({bus2.scan_done_o, bus2.overflow_o} !== 2'b11) begin
      errors++; $display("FAIL ovf_done: got %b want 11", {bus2.scan_done_o, bus2.overflow_o});
    end
    tick();
    checks++;
    if ({bus2.scan_done_o, bus2.overflow_o} !== 2'b01) begin
      errors++; $display("FAIL ovf_sticky: got %b want 01", {bus2.scan_done_o, bus2.overflow_o});
    end
    bus2.start_i = 1'b1;
    tick();
    bus2.start_i = 1'b0;
    checks++;
    if (bus2.overflow_o !== 1'b0) begin
      errors++; $display("FAIL ovf_clear_on_start: got %0d want 0", bus2.overflow_o);
    end
    bus2.abort_i = 1'b1;
    tick();
    bus2.abort_i = 1'b0;
  endtask

  task automatic test_abort_reset();
    logic done_seen = 1'b0;
    launch1(3'd1, 3'd3, 6'd32, 6'd5);
    for (int i = 0; i < 50; i++) tick();
    checks++;
    if ({bus1.ag_k_o, bus1.ag_xcor_o} !== {3'd2, 6'd7}) begin
      errors++; $display("FAIL abort_beat50: got %h want %h", {bus1.ag_k_o, bus1.ag_xcor_o}, {3'd2, 6'd7});
    end
    bus1.abort_i = 1'b1;
    tick();
    bus1.abort_i = 1'b0;
    checks++;
    if ({bus1.ag_en_o, bus1.busy_o} !== 2'b00) begin
      errors++; $display("FAIL abort_idle: got %b want 00", {bus1.ag_en_o, bus1.busy_o});
    end
    for (int i = 0; i < 5; i++) begin
      done_seen |= bus1.scan_done_o;
      tick();
    end
    checks++;
    if (done_seen !== 1'b0) begin
      errors++; $display("FAIL abort_no_done: got %0d want 0", done_seen);
    end
    launch1(3'd1, 3'd3, 6'd32, 6'd5);
    tick(); tick(); tick();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (snap1() !== RST_VEC) begin
      errors++; $display("FAIL async_reset: got %h want %h", snap1(), RST_VEC);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (snap1() !== RST_VEC) begin
      errors++; $display("FAIL post_reset_idle: got %h want %h", snap1(), RST_VEC);
    end
  endtask

  initial begin
    test_reset();
    test_full_scan();
    test_stride2();
    test_cfg_err();
    test_stall();
    test_overflow();
    test_abort_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
